dmem_arbiter: RTL

- Shares the single-port data memory between the RISC-V core's load/store path and an external host port (loader/debug/DMA).
- Serialises accesses through a small FSM with fair round-robin arbitration.
- Drives a stall back to the core while its access is pending.
- Sits between Datapath_Unit's memory interface and the data memory array inside the processor top level.

---
 rtl/dmem_arb_pkg.sv | 14 +
 rtl/rr_arb2.sv | 43 ++++
 rtl/dmem_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, grant encoding, counter sizing.
// The optional wait counters in dmem_arbiter are enabled by the DMEM_ARB_PERF_EN macro.
package dmem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;

  typedef enum logic {GNT_CPU, GNT_HOST} gnt_t;

  // Width of a down-counter that must hold values 0..lat.
  function automatic int unsigned lat_cnt_w(input int unsigned lat);
    return (lat < 2) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick (CPU vs HOST) with a registered last-grant pointer.
// Reusable for any two-requester single-port resource.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic cpu_req_i,
  input  logic host_req_i,
  input  logic take_i,
  output logic valid_c_o,
  output logic gnt_host_c_o
);

  gnt_t last_q, last_d;
  gnt_t pick_c;

  // On a tie the side that did not win last time is preferred.
  always_comb begin
    pick_c = GNT_CPU;
    last_d = last_q;
    if (cpu_req_i && host_req_i) begin
      pick_c = (last_q == GNT_HOST) ? GNT_CPU : GNT_HOST;
    end else if (host_req_i) begin
      pick_c = GNT_HOST;
    end
    if (take_i && (cpu_req_i || host_req_i)) begin
      last_d = pick_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= GNT_HOST;
    end else begin
      last_q <= last_d;
    end
  end

  assign valid_c_o    = cpu_req_i | host_req_i;
  assign gnt_host_c_o = (pick_c == GNT_HOST);

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises core load/store and host accesses onto the single-port data memory.
// Define DMEM_ARB_PERF_EN to add per-side saturating wait-cycle counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned Bits    = 32,
  parameter int unsigned MemSize = 32,
  parameter int unsigned MemLat  = 1,
  localparam int unsigned AW     = $clog2(MemSize)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cpu_req,
  input  logic            cpu_we,
  input  logic [AW-1:0]   cpu_addr,
  input  logic [Bits-1:0] cpu_wdata,
  output logic [Bits-1:0] cpu_rdata,
  output logic            cpu_done,
  output logic            cpu_stall,
  input  logic            host_req,
  input  logic            host_we,
  input  logic [AW-1:0]   host_addr,
  input  logic [Bits-1:0] host_wdata,
  output logic [Bits-1:0] host_rdata,
  output logic            host_ack,
`ifdef DMEM_ARB_PERF_EN
  output logic [31:0]     cpu_wait_cnt,
  output logic [31:0]     host_wait_cnt,
`endif
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [Bits-1:0] mem_wdata,
  input  logic [Bits-1:0] mem_rdata
);

  localparam int unsigned CntW = lat_cnt_w(MemLat);

  arb_state_t      state_q, state_d;
  gnt_t            gnt_q, gnt_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            we_q, we_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [Bits-1:0] mem_wdata_q, mem_wdata_d;
  logic [Bits-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [Bits-1:0] host_rdata_q, host_rdata_d;
  logic            cpu_done_q, cpu_done_d;
  logic            host_ack_q, host_ack_d;

  logic            arb_valid_c;
  logic            arb_host_c;
  logic            take_c;

  rr_arb2 u_rr_arb2 (
    .clk          (clk),
    .rst          (rst),
    .cpu_req_i    (cpu_req),
    .host_req_i   (host_req),
    .take_i       (take_c),
    .valid_c_o    (arb_valid_c),
    .gnt_host_c_o (arb_host_c)
  );

  // Next-state and registered-output decode.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;
    cpu_done_d   = 1'b0;
    host_ack_d   = 1'b0;
    take_c       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_valid_c) begin
          take_c   = 1'b1;
          mem_en_d = 1'b1;
          state_d  = ISSUE;
          if (arb_host_c) begin
            gnt_d       = GNT_HOST;
            we_d        = host_we;
            mem_we_d    = host_we;
            mem_addr_d  = host_addr;
            mem_wdata_d = host_wdata;
          end else begin
            gnt_d       = GNT_CPU;
            we_d        = cpu_we;
            mem_we_d    = cpu_we;
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
          end
        end
      end
      ISSUE: begin
        cnt_d   = CntW'(MemLat);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == CntW'(1)) begin
          state_d = DONE;
          if (gnt_q == GNT_HOST) begin
            host_ack_d = 1'b1;
            if (!we_q) host_rdata_d = mem_rdata;
          end else begin
            cpu_done_d = 1'b1;
            if (!we_q) cpu_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      gnt_q        <= GNT_CPU;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
      cpu_done_q   <= 1'b0;
      host_ack_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
      cpu_done_q   <= cpu_done_d;
      host_ack_q   <= host_ack_d;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] cpu_wait_q, cpu_wait_d;
  logic [31:0] host_wait_q, host_wait_d;

  // Count requesting cycles outside the side's own DONE cycle, saturating.
  always_comb begin
    cpu_wait_d  = cpu_wait_q;
    host_wait_d = host_wait_q;
    if (cpu_req && !(state_q == DONE && gnt_q == GNT_CPU) && (cpu_wait_q != '1)) begin
      cpu_wait_d = cpu_wait_q + 32'd1;
    end
    if (host_req && !(state_q == DONE && gnt_q == GNT_HOST) && (host_wait_q != '1)) begin
      host_wait_d = host_wait_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_wait_q  <= '0;
      host_wait_q <= '0;
    end else begin
      cpu_wait_q  <= cpu_wait_d;
      host_wait_q <= host_wait_d;
    end
  end

  assign cpu_wait_cnt  = cpu_wait_q;
  assign host_wait_cnt = host_wait_q;
`endif

  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign host_rdata = host_rdata_q;
  assign cpu_done   = cpu_done_q;
  assign host_ack   = host_ack_q;
  // The core advances in its done cycle, so the stall drops there.
  assign cpu_stall  = cpu_req & ~cpu_done_q;

endmodule
